// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the default parameter values and the NOP control word
// that a bubble loads into the EX stage.
package id_ex_stage_pkg;

  localparam int unsigned DEFAULT_DATA_BUS_SIZE   = 32;
  localparam int unsigned DEFAULT_REG_ADDR_SIZE   = 5;
  localparam int unsigned DEFAULT_OP_ALU_BUS_SIZE = 2;
  localparam int unsigned DEFAULT_BUBBLE_CNT_SIZE = 16;

  // Single-bit controls produced by main control.
  typedef struct packed {
    logic wb_reg_write;
    logic wb_mem_to_reg;
    logic mem_branch;
    logic mem_read;
    logic mem_write;
    logic ex_dest;
    logic ex_alu_src;
  } ctrl_t;

  // All controls deasserted: no write-back, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// hazard_detection_unit: combinational load-use detector.
// Ports:
//   i_ex_mem_read  instruction currently in EX is a load
//   i_ex_rt        destination register of that load
//   i_id_rs/i_id_rt source registers of the instruction in ID
//   o_hazard       ID instruction reads the load's destination
//                  ($0 never counts since it cannot be written)
module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_SIZE = 5
) (
  input  logic                     i_ex_mem_read,
  input  logic [REG_ADDR_SIZE-1:0] i_ex_rt,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rs,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rt,
  output logic                     o_hazard
);

  always_comb begin
    o_hazard = i_ex_mem_read && (i_ex_rt != '0) &&
               ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Registers main-control outputs and decoded operands for EX, detects
// load-use hazards (o_stall freezes PC and IF/ID while a bubble is
// injected), discards the ID instruction on branch flush, holds all
// state while i_enable is low, and counts injected bubbles (saturating).
// Ports:
//   i_clk, i_reset (sync, active high), i_enable (advance), i_flush
//   i_* control/data from ID       -> o_* registered copies for EX
//   o_stall         combinational stall request
//   o_bubble_count  bubbles injected since reset
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE   = DEFAULT_DATA_BUS_SIZE,
  parameter int unsigned REG_ADDR_SIZE   = DEFAULT_REG_ADDR_SIZE,
  parameter int unsigned OP_ALU_BUS_SIZE = DEFAULT_OP_ALU_BUS_SIZE,
  parameter int unsigned BUBBLE_CNT_SIZE = DEFAULT_BUBBLE_CNT_SIZE
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_flush,
  input  logic                       i_wb_reg_write,
  input  logic                       i_wb_mem_to_reg,
  input  logic                       i_mem_branch,
  input  logic                       i_mem_read,
  input  logic                       i_mem_write,
  input  logic                       i_ex_dest,
  input  logic                       i_ex_alu_src,
  input  logic [OP_ALU_BUS_SIZE-1:0] i_ex_alu_op,
  input  logic [DATA_BUS_SIZE-1:0]   i_rs_data,
  input  logic [DATA_BUS_SIZE-1:0]   i_rt_data,
  input  logic [DATA_BUS_SIZE-1:0]   i_imm,
  input  logic [DATA_BUS_SIZE-1:0]   i_pc_next,
  input  logic [REG_ADDR_SIZE-1:0]   i_rs,
  input  logic [REG_ADDR_SIZE-1:0]   i_rt,
  input  logic [REG_ADDR_SIZE-1:0]   i_rd,
  output logic                       o_wb_reg_write,
  output logic                       o_wb_mem_to_reg,
  output logic                       o_mem_branch,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic                       o_ex_dest,
  output logic                       o_ex_alu_src,
  output logic [OP_ALU_BUS_SIZE-1:0] o_ex_alu_op,
  output logic [DATA_BUS_SIZE-1:0]   o_rs_data,
  output logic [DATA_BUS_SIZE-1:0]   o_rt_data,
  output logic [DATA_BUS_SIZE-1:0]   o_imm,
  output logic [DATA_BUS_SIZE-1:0]   o_pc_next,
  output logic [REG_ADDR_SIZE-1:0]   o_rs,
  output logic [REG_ADDR_SIZE-1:0]   o_rt,
  output logic [REG_ADDR_SIZE-1:0]   o_rd,
  output logic                       o_stall,
  output logic [BUBBLE_CNT_SIZE-1:0] o_bubble_count
);

  ctrl_t                      ctrl_d, ctrl_q;
  logic [OP_ALU_BUS_SIZE-1:0] alu_op_d, alu_op_q;
  logic [DATA_BUS_SIZE-1:0]   rs_data_d, rs_data_q;
  logic [DATA_BUS_SIZE-1:0]   rt_data_d, rt_data_q;
  logic [DATA_BUS_SIZE-1:0]   imm_d, imm_q;
  logic [DATA_BUS_SIZE-1:0]   pc_next_d, pc_next_q;
  logic [REG_ADDR_SIZE-1:0]   rs_d, rs_q;
  logic [REG_ADDR_SIZE-1:0]   rt_d, rt_q;
  logic [REG_ADDR_SIZE-1:0]   rd_d, rd_q;
  logic [BUBBLE_CNT_SIZE-1:0] bubble_cnt_d, bubble_cnt_q;
  logic                       hazard;

  hazard_detection_unit #(
    .REG_ADDR_SIZE(REG_ADDR_SIZE)
  ) u_hazard (
    .i_ex_mem_read(ctrl_q.mem_read),
    .i_ex_rt      (rt_q),
    .i_id_rs      (i_rs),
    .i_id_rt      (i_rt),
    .o_hazard     (hazard)
  );

  // A flush already discards the ID instruction, so no stall is needed.
  always_comb begin
    o_stall = hazard && !i_flush && !i_reset;
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    alu_op_d     = alu_op_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    pc_next_d    = pc_next_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_enable) begin
      if (i_flush || hazard) begin
        ctrl_d    = CTRL_NOP;
        alu_op_d  = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        pc_next_d = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
      end else begin
        ctrl_d.wb_reg_write  = i_wb_reg_write;
        ctrl_d.wb_mem_to_reg = i_wb_mem_to_reg;
        ctrl_d.mem_branch    = i_mem_branch;
        ctrl_d.mem_read      = i_mem_read;
        ctrl_d.mem_write     = i_mem_write;
        ctrl_d.ex_dest       = i_ex_dest;
        ctrl_d.ex_alu_src    = i_ex_alu_src;
        alu_op_d             = i_ex_alu_op;
        rs_data_d            = i_rs_data;
        rt_data_d            = i_rt_data;
        imm_d                = i_imm;
        pc_next_d            = i_pc_next;
        rs_d                 = i_rs;
        rt_d                 = i_rt;
        rd_d                 = i_rd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_q       <= CTRL_NOP;
      alu_op_q     <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      pc_next_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_op_q     <= alu_op_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      pc_next_q    <= pc_next_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    o_wb_reg_write  = ctrl_q.wb_reg_write;
    o_wb_mem_to_reg = ctrl_q.wb_mem_to_reg;
    o_mem_branch    = ctrl_q.mem_branch;
    o_mem_read      = ctrl_q.mem_read;
    o_mem_write     = ctrl_q.mem_write;
    o_ex_dest       = ctrl_q.ex_dest;
    o_ex_alu_src    = ctrl_q.ex_alu_src;
    o_ex_alu_op     = alu_op_q;
    o_rs_data       = rs_data_q;
    o_rt_data       = rt_data_q;
    o_imm           = imm_q;
    o_pc_next       = pc_next_q;
    o_rs            = rs_q;
    o_rt            = rt_q;
    o_rd            = rd_q;
    o_bubble_count  = bubble_cnt_q;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures main-control outputs plus decoded operands each cycle and presents them to EX.
- Contains load-use hazard detection: drives a stall to PC/IF-ID and injects a bubble into EX.
- Also handles branch flush, debug single-step enable, and a saturating bubble counter for the debug unit.

Parameters:
- DATA_BUS_SIZE, 32, width of register data, immediate and PC.
- REG_ADDR_SIZE, 5, register-file address width.
- OP_ALU_BUS_SIZE, 2, width of ALU op from main control.
- BUBBLE_CNT_SIZE, 16, width of bubble statistics counter.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance (debug step); 0 = hold all registers
- i_flush  in  1  branch taken in MEM; discard ID instruction
- i_wb_reg_write, i_wb_mem_to_reg, i_mem_branch, i_mem_read, i_mem_write, i_ex_dest, i_ex_alu_src  in  1 each  control from main control
- i_ex_alu_op  in  OP_ALU_BUS_SIZE  ALU op from main control
- i_rs_data, i_rt_data  in  DATA_BUS_SIZE  register-file read data
- i_imm  in  DATA_BUS_SIZE  sign-extended immediate
- i_pc_next  in  DATA_BUS_SIZE  PC+4 of ID instruction
- i_rs, i_rt, i_rd  in  REG_ADDR_SIZE  register fields
- o_<each control/data input above>  out  same width  registered copy for EX
- o_stall  out  1  combinational; freeze PC and IF/ID
- o_bubble_count  out  BUBBLE_CNT_SIZE  bubbles injected since reset, saturating

Behaviour:
- Reset (i_reset=1 at edge): all registered outputs 0, o_bubble_count 0; dominates all other inputs.
- Latency: one cycle, ID inputs at edge N appear on outputs after edge N.
- Hazard: hazard = o_mem_read & (o_rt != 0) & (o_rt == i_rs | o_rt == i_rt). Register 0 never causes a hazard.
- o_stall = hazard & ~i_flush & ~i_reset. Purely combinational, no added latency.
- Edge update priority, after reset:
  1. i_enable=0: hold every register, counter included.
  2. i_flush=1: load bubble.
  3. hazard=1: load bubble.
  4. Otherwise: load all inputs.
- Bubble: every o_ control and data field loaded with 0 (NOP). Counter increments by 1, saturating at all-ones, no wrap.
- Load-use self-clears: the bubble has o_mem_read=0, so o_stall lasts exactly one enabled cycle per load-use pair.
- Undefined (x) control inputs from main control on non-LW/R-type opcodes are registered as-is on normal load. A bubble always forces known 0.
- Flush together with hazard: a single bubble, counted once; o_stall=0.
- i_enable=0 during hazard: o_stall stays high combinationally; no bubble until the next enabled edge.

Decomposition:
- Header id_ex_stage.vh holds the DEFAULT_* parameter values and the NOP control constant.
- Reuse the existing LOW/HIGH macros.
- Sub-module hazard_detection_unit: purely combinational compare producing hazard. Inputs: EX mem_read, EX rt, ID rs, ID rt.

Test Plan:
- Reset: i_reset=1 with all inputs at 1 -> all outputs 0 after edge, o_bubble_count=0.
- Pass-through: R-type ctrl (reg_write=1, ex_dest=1, alu_op=2'b10), rs_data=0x11, rt_data=0x22 -> same values on outputs one edge later; o_stall=0.
- Load-use: LW writing rt=5, next ID has rs=5 -> o_stall=1 that cycle; next edge all outputs 0, count=1; following cycle o_stall=0 and the ID instruction loads.
- $0 guard: LW with rt=0, next ID rs=0 -> o_stall=0, no bubble.
- Flush plus hazard: hazard conditions with i_flush=1 -> o_stall=0, one bubble, count increments by exactly 1.
- Enable/saturation: i_enable=0 for 3 edges with changing inputs -> outputs unchanged; preload count to 0xFFFF, force a bubble -> count stays 0xFFFF.
